// File: rtl/frame_gen_pkg.sv
// Shared definitions for the logo frame generator: scanner state encoding,
// default frame geometry (shared with the logo memory) and the output beat.
package frame_gen_pkg;

  localparam int FRAME_WIDTH_DEF  = 640;
  localparam int FRAME_HEIGHT_DEF = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] pixel;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  // Counter width for a dimension; a 1-wide dimension still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logo_frame_scanner_raster_counter.sv
// Raster-order (x, y) address counter; wraps to (0,0) after the last pixel.
module raster_counter
  import frame_gen_pkg::*;
#(
  parameter int W = FRAME_WIDTH_DEF,
  parameter int H = FRAME_HEIGHT_DEF,
  localparam int XW = cnt_w(W),
  localparam int YW = cnt_w(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          at_eol,
  output logic          at_eof
);

  assign at_eol = (x == XW'(W - 1));
  assign at_eof = at_eol && (y == YW'(H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (at_eol) begin
        x <= '0;
        y <= at_eof ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/logo_frame_scanner.sv
// Walks the logo memory in raster order and streams its pixels as a
// valid/ready beat stream with sof/eol/eof markers.
module logo_frame_scanner
  import frame_gen_pkg::*;
#(
  parameter int FRAME_WIDTH  = FRAME_WIDTH_DEF,
  parameter int FRAME_HEIGHT = FRAME_HEIGHT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  output logic [31:0] mem_x,
  output logic [31:0] mem_y,
  input  logic [1:0]  mem_pix,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_pixel,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt
);

  localparam int XW = cnt_w(FRAME_WIDTH);
  localparam int YW = cnt_w(FRAME_HEIGHT);

  state_t          state, nxt;
  beat_t           beat_q;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            at_eol, at_eof;
  logic            load, accept, eof_acc;

  raster_counter #(.W(FRAME_WIDTH), .H(FRAME_HEIGHT)) u_rc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   ((state == IDLE) || abort),
    .advance (load && !abort),
    .x       (x),
    .y       (y),
    .at_eol  (at_eol),
    .at_eof  (at_eof)
  );

  assign mem_x     = 32'(x);
  assign mem_y     = 32'(y);
  assign out_pixel = beat_q.pixel;
  assign out_sof   = beat_q.sof;
  assign out_eol   = beat_q.eol;
  assign out_eof   = beat_q.eof;
  assign busy      = (state != IDLE);
  assign accept    = out_valid && out_ready;
  // The only beat outstanding in FLUSH is the eof beat.
  assign eof_acc   = (state == FLUSH) && accept && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    case (state)
      IDLE:  if (start) nxt = SCAN;
      SCAN: begin
        load = !out_valid || out_ready;
        if (load && at_eof) nxt = FLUSH;
      end
      FLUSH: if (accept) nxt = continuous ? SCAN : IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q    <= '0;
      out_valid <= 1'b0;
    end else if (abort) begin
      out_valid  <= 1'b0;
      beat_q.sof <= 1'b0;
      beat_q.eol <= 1'b0;
      beat_q.eof <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      beat_q    <= '{pixel: mem_pix, sof: (x == '0) && (y == '0),
                     eol: at_eol, eof: at_eof};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done <= eof_acc;
      if (eof_acc) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_logo_frame_scanner.sv
// Scoreboard bench for logo_frame_scanner at W=4, H=3 with pix=(x+y)%4.
module tb_logo_frame_scanner;
  import frame_gen_pkg::*;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        start = 1'b0, continuous = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [31:0] mem_x, mem_y;
  logic [1:0]  mem_pix;
  logic        out_valid, out_sof, out_eol, out_eof, busy, done;
  logic [1:0]  out_pixel;
  logic [15:0] frame_cnt;

  logo_frame_scanner #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .mem_x(mem_x), .mem_y(mem_y), .mem_pix(mem_pix),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  assign mem_pix = 2'(mem_x + mem_y);

  beat_t exp_q[$];
  int checks = 0, failures = 0;
  int acc_cnt = 0, done_cnt = 0, eof_cnt = 0, cyc = 0;
  int max_x = 0, max_y = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_n(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.pixel = 2'((i % W + i / W) % 4);
      b.sof   = (i == 0);
      b.eol   = (i % W == W - 1);
      b.eof   = (i == W * H - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("wait_beats", 32'(acc_cnt >= target), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_pixel"}, 32'(out_pixel), 0);
    chk({tag, "_markers"}, 32'({out_sof, out_eol, out_eof}), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, "_mem_x"}, mem_x, 0);
    chk({tag, "_mem_y"}, mem_y, 0);
  endtask

  // Monitor: sample at negedge, when inputs are settled for the next edge.
  initial begin : monitor
    beat_t b, held;
    logic  held_v, gap_pend;
    int    eof_cyc;
    held_v = 1'b0; gap_pend = 1'b0; eof_cyc = 0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (int'(mem_x) > max_x) max_x = int'(mem_x);
      if (int'(mem_y) > max_y) max_y = int'(mem_y);
      if (held_v && out_valid)
        chk("stable_while_stalled", 32'({out_pixel, out_sof, out_eol, out_eof}), 32'(held));
      if (gap_pend && out_valid) begin
        chk("eof_to_sof_gap", 32'(cyc - eof_cyc), 32'd2);
        chk("sof_after_gap", 32'(out_sof), 32'd1);
        gap_pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          chk("beat_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          b = exp_q.pop_front();
          chk("beat", 32'({out_pixel, out_sof, out_eol, out_eof}), 32'(b));
        end
        if (out_eof) begin
          eof_cnt++;
          if (continuous) begin
            gap_pend = 1'b1;
            eof_cyc  = cyc;
          end
        end
        held_v = 1'b0;
      end else begin
        held_v = out_valid;
        held   = '{pixel: out_pixel, sof: out_sof, eol: out_eol, eof: out_eof};
      end
    end
  end

  initial begin : stim
    int base, n;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, ready held high
    out_ready = 1'b1;
    base = acc_cnt;
    push_n(W * H);
    pulse_start();
    @(posedge clk); #1;
    chk("first_beat_sof", 32'(out_valid && out_sof), 32'd1);
    wait_acc(base + W * H);
    chk("busy_after_eof", 32'(busy), 0);
    chk("done_pulse", 32'(done), 1);
    chk("frame_cnt_1", 32'(frame_cnt), 1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("done_count_1", 32'(done_cnt), 1);

    // Random backpressure plus stray start pulses while scanning
    base = acc_cnt;
    push_n(W * H);
    pulse_start();
    n = 0;
    while (acc_cnt < base + W * H && n < 500) begin
      out_ready = 1'($urandom_range(0, 1));
      start     = (n == 5 || n == 9);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("random_ready_done", 32'(acc_cnt >= base + W * H), 1);
    repeat (3) @(posedge clk); #1;
    chk("frame_cnt_2", 32'(frame_cnt), 2);
    chk("busy_idle_2", 32'(busy), 0);
    chk("queue_empty_2", 32'(exp_q.size()), 0);

    // Three continuous frames
    base = acc_cnt;
    n = eof_cnt;
    push_n(W * H); push_n(W * H); push_n(W * H);
    continuous = 1'b1;
    pulse_start();
    while (eof_cnt < n + 2 && cyc < 5000) @(posedge clk);
    #1 continuous = 1'b0;
    wait_acc(base + 3 * W * H);
    repeat (2) @(posedge clk); #1;
    chk("frame_cnt_5", 32'(frame_cnt), 5);
    chk("done_count_5", 32'(done_cnt), 5);
    chk("busy_idle_5", 32'(busy), 0);
    chk("max_x", 32'(max_x), W - 1);
    chk("max_y", 32'(max_y), H - 1);

    // Abort after six beats, coincident with start
    base = acc_cnt;
    push_n(6);
    pulse_start();
    wait_acc(base + 6);
    out_ready = 1'b0;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_markers", 32'({out_sof, out_eol, out_eof}), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_addr", mem_x | mem_y, 0);
    @(posedge clk); #1;
    chk("abort_no_done", 32'(done_cnt), 5);
    chk("abort_frame_cnt", 32'(frame_cnt), 5);
    chk("abort_queue_empty", 32'(exp_q.size()), 0);
    out_ready = 1'b1;
    base = acc_cnt;
    push_n(W * H);
    pulse_start();
    @(posedge clk); #1;
    chk("restart_sof", 32'(out_valid && out_sof), 1);
    wait_acc(base + W * H);
    chk("frame_cnt_6", 32'(frame_cnt), 6);

    // Asynchronous reset mid-frame
    @(posedge clk); #1;
    base = acc_cnt;
    push_n(W * H);
    pulse_start();
    wait_acc(base + 4);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n = done_cnt;
    base = acc_cnt;
    push_n(W * H);
    pulse_start();
    @(posedge clk); #1;
    chk("post_reset_sof", 32'(out_valid && out_sof), 1);
    wait_acc(base + W * H);
    chk("post_reset_busy", 32'(busy), 0);
    chk("post_reset_frame_cnt", 32'(frame_cnt), 1);
    @(posedge clk); #1;
    chk("post_reset_done", 32'(done_cnt - n), 1);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
